rs485_addr_responder: RTL and testbench

//  Parametrised successor to the fixed-width RS485 PSLV sequence detector/transmitter.

---
 rtl/rs485_pkg.sv | 36 +++
 rtl/rs485_uart_rx.sv | 169 ++++++++++++++++
 rtl/rs485_addr_responder.sv | 204 ++++++++++++++++++++
 tb/tb_rs485_addr_responder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rs485_pkg.sv
// Shared types and constants for the RS485 address responder.
// Contents:
//   rx_state_t / tx_state_t : receive and transmit FSM state encodings
//   BROADCAST_ADDR          : address that every slave acknowledges but none answers
//   FRAME_STOP / IDLE_LVL   : line levels for the stop bit and for an idle line
//   even_parity()           : parity bit that makes the total count of ones even
package rs485_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_GUARD,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP,
        TX_DONE
    } tx_state_t;

    localparam logic [7:0] BROADCAST_ADDR = 8'hFF;
    localparam logic       FRAME_STOP     = 1'b1;
    localparam logic       IDLE_LVL       = 1'b1;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/rs485_uart_rx.sv
// UART deframer for the RS485 receive line: 2-flop synchroniser plus RX FSM.
// Optional feature macro: RS485_PARITY_EN (even parity bit after the data bits).
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   rx       in   raw receive line, idle high
//   rx_hold  in   forces the FSM to IDLE (used while the slave is transmitting)
//   rx_byte  out  last received byte, valid while rx_valid is high
//   rx_valid out  1-clk pulse: good frame received
//   rx_err   out  1-clk pulse: bad stop bit or parity mismatch
module rs485_uart_rx
    import rs485_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rx_hold,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err
);

    localparam int             CW       = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0]  HALF_CNT = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0]  LAST_CNT = CW'(CLKS_PER_BIT - 1);

    logic            sync1_reg, sync2_reg;
    rx_state_t       state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [2:0]      bit_reg, bit_next;
    logic [7:0]      shift_reg, shift_next;
    logic            valid_reg, valid_next;
    logic            err_reg, err_next;
`ifdef RS485_PARITY_EN
    logic            par_bad_reg, par_bad_next;
`endif

    logic rx_s;
    logic start_edge;

    assign rx_s = sync2_reg;
    // The falling edge is spotted as it enters the last synchroniser flop, so
    // the START state lines up with the first cycle of the synced start bit.
    // This is what lets CLKS_PER_BIT=1 sample the start bit on the next clk.
    assign start_edge = (sync2_reg == IDLE_LVL) && (sync1_reg != IDLE_LVL);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg   <= 1'b1;
            sync2_reg   <= 1'b1;
            state_reg   <= RX_IDLE;
            cnt_reg     <= '0;
            bit_reg     <= '0;
            shift_reg   <= '0;
            valid_reg   <= 1'b0;
            err_reg     <= 1'b0;
`ifdef RS485_PARITY_EN
            par_bad_reg <= 1'b0;
`endif
        end else begin
            sync1_reg   <= rx;
            sync2_reg   <= sync1_reg;
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_reg     <= bit_next;
            shift_reg   <= shift_next;
            valid_reg   <= valid_next;
            err_reg     <= err_next;
`ifdef RS485_PARITY_EN
            par_bad_reg <= par_bad_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        bit_next     = bit_reg;
        shift_next   = shift_reg;
        valid_next   = 1'b0;
        err_next     = 1'b0;
`ifdef RS485_PARITY_EN
        par_bad_next = par_bad_reg;
`endif
        case (state_reg)
            RX_IDLE: begin
                if (start_edge) begin
                    state_next = RX_START;
                    cnt_next   = '0;
                end
            end
            RX_START: begin
                if (cnt_reg == HALF_CNT) begin
                    cnt_next = '0;
                    bit_next = '0;
                    // Line back high at mid-start: glitch, not a frame.
                    state_next = (rx_s == IDLE_LVL) ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_reg == LAST_CNT) begin
                    cnt_next   = '0;
                    shift_next = {rx_s, shift_reg[7:1]};
                    bit_next   = bit_reg + 1'b1;
                    if (bit_reg == 3'd7) begin
`ifdef RS485_PARITY_EN
                        state_next = RX_PARITY;
`else
                        state_next = RX_STOP;
`endif
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
`ifdef RS485_PARITY_EN
            RX_PARITY: begin
                if (cnt_reg == LAST_CNT) begin
                    cnt_next     = '0;
                    par_bad_next = rx_s ^ even_parity(shift_reg);
                    state_next   = RX_STOP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
`endif
            RX_STOP: begin
                if (cnt_reg == LAST_CNT) begin
                    cnt_next = '0;
                    if (rx_s != FRAME_STOP) begin
                        err_next   = 1'b1;
                        state_next = RX_WAIT_IDLE;
`ifdef RS485_PARITY_EN
                    end else if (par_bad_reg) begin
                        err_next   = 1'b1;
                        state_next = RX_IDLE;
`endif
                    end else begin
                        valid_next = 1'b1;
                        state_next = RX_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RX_WAIT_IDLE: begin
                if (rx_s == IDLE_LVL) begin
                    state_next = RX_IDLE;
                end
            end
            default: state_next = RX_IDLE;
        endcase

        if (rx_hold) begin
            state_next = RX_IDLE;
            valid_next = 1'b0;
            err_next   = 1'b0;
        end
    end

    assign rx_byte  = shift_reg;
    assign rx_valid = valid_reg;
    assign rx_err   = err_reg;

endmodule

// File: rtl/rs485_addr_responder.sv
// RS485 slave address responder: deframes bytes from rx, compares each with
// the slave address and answers a match half-duplex with a DATA_BYTES payload
// (most significant byte first, each byte LSB first).
// Optional feature macro: RS485_PARITY_EN (even parity on rx and tx frames).
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   rx           in   RS485 receive line, idle high
//   sa           in   slave address
//   data         in   reply payload, captured on an address match
//   tx_en        out  transceiver driver enable
//   tx           out  serial transmit line, idle high
//   tx_complete  out  1-clk pulse after the final stop bit
//   seq_detected out  1-clk pulse on address (or broadcast) match
//   frame_err    out  1-clk pulse on bad stop bit or parity error
module rs485_addr_responder
    import rs485_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int DATA_BYTES   = 2,
    parameter int GUARD_BITS   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rx,
    input  logic [7:0]              sa,
    input  logic [8*DATA_BYTES-1:0] data,
    output logic                    tx_en,
    output logic                    tx,
    output logic                    tx_complete,
    output logic                    seq_detected,
    output logic                    frame_err
);

    localparam int             CW         = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0]  LAST_CNT   = CW'(CLKS_PER_BIT - 1);
    localparam int             BW         = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam logic [BW-1:0]  LAST_BYTE  = BW'(DATA_BYTES - 1);
    localparam logic [2:0]     LAST_GUARD = 3'(GUARD_BITS - 1);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;
    logic       rx_hold;
    logic       reply_req;

    tx_state_t                 tx_state_reg, tx_state_next;
    logic [CW-1:0]             cnt_reg, cnt_next;
    logic [2:0]                bit_reg, bit_next;
    logic [BW-1:0]             byte_reg, byte_next;
    logic [2:0]                guard_reg, guard_next;
    logic [8*DATA_BYTES-1:0]   shadow_reg;
    logic [7:0]                byte_arr [DATA_BYTES];
    logic [7:0]                cur_byte;

    // Receiver is deaf from the first guard bit through DONE.
    assign rx_hold = (tx_state_reg != TX_IDLE);

    rs485_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .rx_hold (rx_hold),
        .rx_byte (rx_byte),
        .rx_valid(rx_valid),
        .rx_err  (rx_err)
    );

    assign seq_detected = rx_valid && ((rx_byte == sa) || (rx_byte == BROADCAST_ADDR));
    assign reply_req    = seq_detected && (rx_byte != BROADCAST_ADDR);
    assign frame_err    = rx_err;

    // Payload is frozen at the match so a changing data bus cannot corrupt a reply.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_reg <= '0;
        end else if (seq_detected && (tx_state_reg == TX_IDLE)) begin
            shadow_reg <= data;
        end
    end

    // byte_arr[0] is the most significant payload byte, i.e. the first one sent.
    generate
        for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_bytes
            assign byte_arr[gi] = shadow_reg[8*(DATA_BYTES-1-gi) +: 8];
        end
    endgenerate

    assign cur_byte = byte_arr[byte_reg];

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_reg <= TX_IDLE;
            cnt_reg      <= '0;
            bit_reg      <= '0;
            byte_reg     <= '0;
            guard_reg    <= '0;
        end else begin
            tx_state_reg <= tx_state_next;
            cnt_reg      <= cnt_next;
            bit_reg      <= bit_next;
            byte_reg     <= byte_next;
            guard_reg    <= guard_next;
        end
    end

    always_comb begin
        tx_state_next = tx_state_reg;
        cnt_next      = cnt_reg;
        bit_next      = bit_reg;
        byte_next     = byte_reg;
        guard_next    = guard_reg;
        case (tx_state_reg)
            TX_IDLE: begin
                if (reply_req) begin
                    cnt_next      = '0;
                    bit_next      = '0;
                    byte_next     = '0;
                    guard_next    = '0;
                    tx_state_next = (GUARD_BITS > 0) ? TX_GUARD : TX_START;
                end
            end
            TX_GUARD: begin
                if (cnt_reg == LAST_CNT) begin
                    cnt_next = '0;
                    if (guard_reg == LAST_GUARD) begin
                        tx_state_next = TX_START;
                    end else begin
                        guard_next = guard_reg + 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            TX_START: begin
                if (cnt_reg == LAST_CNT) begin
                    cnt_next      = '0;
                    bit_next      = '0;
                    tx_state_next = TX_DATA;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            TX_DATA: begin
                if (cnt_reg == LAST_CNT) begin
                    cnt_next = '0;
                    bit_next = bit_reg + 1'b1;
                    if (bit_reg == 3'd7) begin
`ifdef RS485_PARITY_EN
                        tx_state_next = TX_PARITY;
`else
                        tx_state_next = TX_STOP;
`endif
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
`ifdef RS485_PARITY_EN
            TX_PARITY: begin
                if (cnt_reg == LAST_CNT) begin
                    cnt_next      = '0;
                    tx_state_next = TX_STOP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
`endif
            TX_STOP: begin
                if (cnt_reg == LAST_CNT) begin
                    cnt_next = '0;
                    if (byte_reg == LAST_BYTE) begin
                        tx_state_next = TX_DONE;
                    end else begin
                        byte_next     = byte_reg + 1'b1;
                        tx_state_next = TX_START;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            TX_DONE: tx_state_next = TX_IDLE;
            default: tx_state_next = TX_IDLE;
        endcase
    end

    always_comb begin
        tx = IDLE_LVL;
        case (tx_state_reg)
            TX_START:  tx = 1'b0;
            TX_DATA:   tx = cur_byte[bit_reg];
`ifdef RS485_PARITY_EN
            TX_PARITY: tx = even_parity(cur_byte);
`endif
            default:   tx = IDLE_LVL;
        endcase
    end

    assign tx_en       = (tx_state_reg != TX_IDLE) && (tx_state_reg != TX_DONE);
    assign tx_complete = (tx_state_reg == TX_DONE);

endmodule

// File: tb/tb_rs485_addr_responder.sv
module tb_rs485_addr_responder;

`ifdef RS485_PARITY_EN
    localparam int CPB = 4;
    localparam int NB  = 3;
    localparam bit PAR = 1'b1;
`else
    localparam int CPB = 1;
    localparam int NB  = 2;
    localparam bit PAR = 1'b0;
`endif
    localparam int GB  = 1;
    localparam int FB  = PAR ? 11 : 10;
    localparam int WIN = (GB + NB * FB) * CPB + 30;

    logic            clk = 1'b0;
    logic            rst;
    logic            rx;
    logic [7:0]      sa;
    logic [8*NB-1:0] data;
    logic            tx_en, tx, tx_complete, seq_detected, frame_err;

    rs485_addr_responder #(
        .CLKS_PER_BIT(CPB),
        .DATA_BYTES  (NB),
        .GUARD_BITS  (GB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .sa          (sa),
        .data        (data),
        .tx_en       (tx_en),
        .tx          (tx),
        .tx_complete (tx_complete),
        .seq_detected(seq_detected),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]   rx_byte;
        logic         stop_bit;
        logic         par_bad;
        logic [7:0]   sa;
        logic [127:0] data;
        logic         mutate;
        int           exp_seq;
        int           exp_err;
        int           exp_reply;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    // Per-transaction observations, all written from the main process only.
    int           cyc = 0;
    int           seq_cnt, err_cnt, done_cnt, idle_bad;
    int           seq_cyc, done_cyc, en_rise_cyc, last_en_cyc;
    logic         prev_en;
    logic [511:0] got_bits;
    int           got_len;
    logic         mutate_pending;

    task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    task automatic clear_stats();
        seq_cnt = 0; err_cnt = 0; done_cnt = 0; idle_bad = 0;
        seq_cyc = -1; done_cyc = -1; en_rise_cyc = -1; last_en_cyc = -1;
        got_bits = '0; got_len = 0; prev_en = 1'b0; mutate_pending = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (seq_detected) begin seq_cnt++; seq_cyc = cyc; end
        if (frame_err) err_cnt++;
        if (tx_complete) begin done_cnt++; done_cyc = cyc; end
        if (tx_en) begin
            if (!prev_en) en_rise_cyc = cyc;
            last_en_cyc = cyc;
            if (got_len < 512) got_bits[got_len] = tx;
            got_len++;
            if (mutate_pending) begin
                data = ~data;
                mutate_pending = 1'b0;
            end
        end else if (tx !== 1'b1) begin
            idle_bad++;
        end
        prev_en = tx_en;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_bad);
        logic [10:0] fr;
        logic        pbit;
        pbit = (^b) ^ par_bad;
        fr = {stop, pbit, b, 1'b0};
        if (!PAR) fr[9] = stop;
        for (int k = 0; k < FB; k++) begin
            rx = fr[k];
            repeat (CPB) step();
        end
        rx = 1'b1;
    endtask

    // Expected tx waveform while tx_en is high, one entry per clk.
    task automatic build_exp(input logic [8*NB-1:0] d, output logic [511:0] bits, output int len);
        logic [7:0]  b;
        logic [10:0] fr;
        bits = '0;
        len = 0;
        for (int g = 0; g < GB * CPB; g++) begin bits[len] = 1'b1; len++; end
        for (int i = NB - 1; i >= 0; i--) begin
            b = d[8*i +: 8];
            fr = {1'b1, ^b, b, 1'b0};
            if (!PAR) fr[9] = 1'b1;
            for (int k = 0; k < FB; k++)
                for (int c = 0; c < CPB; c++) begin bits[len] = fr[k]; len++; end
        end
    endtask

    task automatic run_vector(input int idx, input vec_t v);
        logic [511:0] eb;
        int           el;
        sa   = v.sa;
        data = v.data[8*NB-1:0];
        clear_stats();
        mutate_pending = v.mutate;
        if (v.exp_reply != 0) build_exp(v.data[8*NB-1:0], eb, el);
        else begin eb = '0; el = 0; end
        send_frame(v.rx_byte, v.stop_bit, v.par_bad);
        repeat (WIN) step();
        check($sformatf("v%0d_seq_cnt", idx), 512'(seq_cnt), 512'(v.exp_seq));
        check($sformatf("v%0d_err_cnt", idx), 512'(err_cnt), 512'(v.exp_err));
        check($sformatf("v%0d_done_cnt", idx), 512'(done_cnt), 512'(v.exp_reply));
        check($sformatf("v%0d_reply_len", idx), 512'(got_len), 512'(el));
        check($sformatf("v%0d_reply_bits", idx), got_bits, eb);
        check($sformatf("v%0d_idle_tx", idx), 512'(idle_bad), 512'(0));
        if (v.exp_reply != 0) begin
            check($sformatf("v%0d_en_rise", idx), 512'(en_rise_cyc), 512'(seq_cyc + 1));
            check($sformatf("v%0d_done_timing", idx), 512'(done_cyc), 512'(last_en_cyc + 1));
        end
        $display("vec %0d byte=%02h sa=%02h seq=%0d err=%0d done=%0d reply_clks=%0d",
                 idx, v.rx_byte, v.sa, seq_cnt, err_cnt, done_cnt, got_len);
    endtask

    vec_t vecs[10];
    int   nv;
    int   waited;

    initial begin
        nv = 0;
        vecs[nv++] = '{8'h01, 1'b1, 1'b0, 8'h01, 128'h3FE0, 1'b0, 1, 0, 1};
        vecs[nv++] = '{8'h02, 1'b1, 1'b0, 8'h01, 128'h3FE0, 1'b0, 0, 0, 0};
        vecs[nv++] = '{8'h01, 1'b0, 1'b0, 8'h01, 128'h3FE0, 1'b0, 0, 1, 0};
        vecs[nv++] = '{8'h01, 1'b1, 1'b0, 8'h01, 128'h3FE0, 1'b0, 1, 0, 1};
        vecs[nv++] = '{8'hFF, 1'b1, 1'b0, 8'h01, 128'h3FE0, 1'b0, 1, 0, 0};
        vecs[nv++] = '{8'h5A, 1'b1, 1'b0, 8'h5A, 128'hC3A55A, 1'b1, 1, 0, 1};
        vecs[nv++] = '{8'h80, 1'b1, 1'b0, 8'h80, 128'h0180FE, 1'b0, 1, 0, 1};
`ifdef RS485_PARITY_EN
        vecs[nv++] = '{8'h01, 1'b1, 1'b1, 8'h01, 128'h3FE0, 1'b0, 0, 1, 0};
        vecs[nv++] = '{8'h07, 1'b1, 1'b1, 8'h07, 128'h123456, 1'b0, 0, 1, 0};
`endif

        rst = 1'b1; rx = 1'b1; sa = 8'h01; data = '0;
        clear_stats();
        repeat (3) step();
        check("rst_tx", 512'(tx), 512'(1));
        check("rst_tx_en", 512'(tx_en), 512'(0));
        check("rst_tx_complete", 512'(tx_complete), 512'(0));
        check("rst_seq_detected", 512'(seq_detected), 512'(0));
        check("rst_frame_err", 512'(frame_err), 512'(0));
        rst = 1'b0;
        repeat (4) step();

        for (int i = 0; i < nv; i++) run_vector(i, vecs[i]);

        // Reset during the second reply byte aborts the reply silently.
        sa = 8'h01; data = (8*NB)'(16'h3FE0);
        clear_stats();
        send_frame(8'h01, 1'b1, 1'b0);
        waited = 0;
        while (seq_cnt == 0 && waited < 100 * CPB) begin step(); waited++; end
        check("abort_seq_seen", 512'(seq_cnt), 512'(1));
        repeat ((GB + FB + 3) * CPB) step();
        check("abort_mid_byte2_en", 512'(tx_en), 512'(1));
        rst = 1'b1;
        step();
        check("abort_tx", 512'(tx), 512'(1));
        check("abort_tx_en", 512'(tx_en), 512'(0));
        check("abort_tx_complete", 512'(tx_complete), 512'(0));
        rst = 1'b0;
        repeat (60 * CPB) step();
        check("abort_no_done", 512'(done_cnt), 512'(0));
        $display("vec abort byte=01 sa=01 seq=%0d done=%0d", seq_cnt, done_cnt);
        run_vector(99, vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
